// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for one shared 8-op ALU.
// Three-state sequencer (IDLE/EXEC/RESP) with a registered, id-tagged result port.
module alu_rr_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W:0]   res_data,
  output logic              res_id,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_r;
  logic              last_id_r;
  logic [2:0]        op_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic              id_r;
  logic              res_valid_r;
  logic [DATA_W:0]   res_data_r;
  logic              res_id_r;
  logic              grant_valid_s;
  logic              grant_id_s;

  // Operands are zero-extended so add/increment carry and subtract wrap land in the top bit.
  function automatic logic [DATA_W:0] alu_eval(input logic [2:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W:0] ax;
    logic [DATA_W:0] bx;
    logic [DATA_W:0] one;
    ax  = {1'b0, a};
    bx  = {1'b0, b};
    one = {{DATA_W{1'b0}}, 1'b1};
    case (op)
      3'b000:  alu_eval = ax + bx;
      3'b001:  alu_eval = ax - bx;
      3'b010:  alu_eval = ax + one;
      3'b011:  alu_eval = bx + one;
      3'b100:  alu_eval = {1'b0, ~a};
      3'b101:  alu_eval = {1'b0, ~b};
      3'b110:  alu_eval = {1'b0, a & b};
      3'b111:  alu_eval = {1'b0, a | b};
      default: alu_eval = {(DATA_W+1){1'b0}};
    endcase
  endfunction

  // Grant selection: a lone requester wins; on contention the loser of the last grant wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = ~last_id_r;
    end else if (req0_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b0;
    end else if (req1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  assign req0_ready = (state_r == IDLE) && grant_valid_s && !grant_id_s;
  assign req1_ready = (state_r == IDLE) && grant_valid_s && grant_id_s;
  assign res_valid  = res_valid_r;
  assign res_data   = res_data_r;
  assign res_id     = res_id_r;
  assign busy       = (state_r != IDLE);

  // Sequencer, capture registers and result registers; last_id_r=1 after reset favours requester 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      last_id_r   <= 1'b1;
      op_r        <= 3'b000;
      a_r         <= {DATA_W{1'b0}};
      b_r         <= {DATA_W{1'b0}};
      id_r        <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= {(DATA_W+1){1'b0}};
      res_id_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            op_r      <= grant_id_s ? req1_op : req0_op;
            a_r       <= grant_id_s ? req1_a  : req0_a;
            b_r       <= grant_id_s ? req1_b  : req0_b;
            id_r      <= grant_id_s;
            last_id_r <= grant_id_s;
            state_r   <= EXEC;
          end else begin
            state_r   <= IDLE;
          end
        end
        EXEC: begin
          res_data_r  <= alu_eval(op_r, a_r, b_r);
          res_id_r    <= id_r;
          res_valid_r <= 1'b1;
          state_r     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r     <= RESP;
          end
        end
        default: begin
          res_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule
